// File: rtl/mem_io_responder_if.sv
// CPU memory bus plus the host-facing RX/TX byte streams for mem_io_responder.
// The master modport is the CPU/host side and the slave modport is the responder.
`timescale 1ns/1ps
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        program_stop;

  modport master (
    output mem_a, mem_dout, mem_wr, rx_valid, rx_data, tx_ready,
    input  mem_din, io_buffer_full, rx_ready, tx_valid, tx_data, program_stop
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr, rx_valid, rx_data, tx_ready,
    output mem_din, io_buffer_full, rx_ready, tx_valid, tx_data, program_stop
  );
endinterface

// File: rtl/mem_io_responder.sv
// Byte RAM plus memory-mapped I/O (RX/TX FIFOs, stop flag) on a one-access-per-cycle CPU bus.
// Define MEM_IO_CYCLE_COUNTER_EN to build the cycle counter readable at 0x30004-0x30007.
`timescale 1ns/1ps
module mem_io_responder #(
  parameter int RAM_AW       = 17,
  parameter int TX_DEPTH_LOG = 3,
  parameter int RX_DEPTH_LOG = 3
) (
  input logic clk_in,
  input logic rst_in,
  mem_io_responder_if.slave bus
);
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG:0] TX_FULL_CNT   = (TX_DEPTH_LOG + 1)'(TX_DEPTH);
  localparam logic [TX_DEPTH_LOG:0] TX_ALMOST_CNT = (TX_DEPTH_LOG + 1)'(TX_DEPTH - 1);
  localparam logic [TX_DEPTH_LOG:0] TX_CNT_ONE    = (TX_DEPTH_LOG + 1)'(1);
  localparam logic [RX_DEPTH_LOG:0] RX_FULL_CNT   = (RX_DEPTH_LOG + 1)'(RX_DEPTH);
  localparam logic [RX_DEPTH_LOG:0] RX_CNT_ONE    = (RX_DEPTH_LOG + 1)'(1);
  localparam logic [TX_DEPTH_LOG-1:0] TX_PTR_ONE  = TX_DEPTH_LOG'(1);
  localparam logic [RX_DEPTH_LOG-1:0] RX_PTR_ONE  = RX_DEPTH_LOG'(1);

  logic [17:0] addr;
  logic [13:0] a_hi_unused;
  logic        is_ram, is_io, hit_data, hit_ctrl, hit_ctrl_lo, wr_en, rd_en;

  assign addr        = bus.mem_a[17:0];
  assign a_hi_unused = bus.mem_a[31:18];
  assign is_ram      = ~addr[17];
  assign is_io       = (addr[17:16] == 2'b11);
  assign hit_data    = is_io & (addr[15:0] == 16'h0000);
  assign hit_ctrl    = is_io & (addr[15:2] == 14'h0001);
  assign hit_ctrl_lo = hit_ctrl & (addr[1:0] == 2'b00);
  // An access presented while reset is asserted must not touch any state.
  assign wr_en       = ~rst_in & bus.mem_wr;
  assign rd_en       = ~rst_in & ~bus.mem_wr;

  // Byte RAM: not reset, read-first synchronous read port.
  logic [7:0]        ram_mem [2**RAM_AW];
  logic [7:0]        ram_q_reg;
  logic [RAM_AW-1:0] ram_addr;

  assign ram_addr = addr[RAM_AW-1:0];

  always_ff @(posedge clk_in) begin
    if (wr_en && is_ram) ram_mem[ram_addr] <= bus.mem_dout;
    ram_q_reg <= ram_mem[ram_addr];
  end

  // TX FIFO (CPU -> host)
  logic [7:0]              tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [TX_DEPTH_LOG:0]   tx_count_reg, tx_count_next;
  logic                    tx_push_req, tx_push, tx_pop, tx_full;
  logic [7:0]              tx_push_data;

  assign tx_full      = (tx_count_reg == TX_FULL_CNT);
  assign tx_pop       = bus.tx_valid & bus.tx_ready;
  assign tx_push_req  = wr_en & ((hit_data & (bus.mem_dout != 8'h00)) | hit_ctrl_lo);
  assign tx_push      = tx_push_req & (~tx_full | tx_pop);
  assign tx_push_data = hit_ctrl_lo ? 8'h00 : bus.mem_dout;

  always_comb begin
    tx_count_next = tx_count_reg;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_next = tx_count_reg + TX_CNT_ONE;
      2'b01:   tx_count_next = tx_count_reg - TX_CNT_ONE;
      default: tx_count_next = tx_count_reg;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + TX_PTR_ONE;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + TX_PTR_ONE;
      tx_count_reg <= tx_count_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg] <= tx_push_data;
  end

  assign bus.tx_valid       = (tx_count_reg != '0);
  assign bus.tx_data        = tx_mem[tx_rd_ptr_reg];
  // Raised one entry early so the CPU sees it before its next write lands.
  assign bus.io_buffer_full = (tx_count_reg >= TX_ALMOST_CNT);

  // RX FIFO (host -> CPU)
  logic [7:0]              rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [RX_DEPTH_LOG:0]   rx_count_reg, rx_count_next;
  logic                    rx_push, rx_pop, rx_nonempty;

  assign rx_nonempty  = (rx_count_reg != '0);
  assign bus.rx_ready = (rx_count_reg != RX_FULL_CNT);
  assign rx_push      = ~rst_in & bus.rx_valid & bus.rx_ready;
  assign rx_pop       = rd_en & hit_data & rx_nonempty;

  always_comb begin
    rx_count_next = rx_count_reg;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_next = rx_count_reg + RX_CNT_ONE;
      2'b01:   rx_count_next = rx_count_reg - RX_CNT_ONE;
      default: rx_count_next = rx_count_reg;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + RX_PTR_ONE;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + RX_PTR_ONE;
      rx_count_reg <= rx_count_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg] <= bus.rx_data;
  end

`ifdef MEM_IO_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt_reg, snap_reg;
  logic [7:0]  snap_byte [4];
  genvar gi;

  for (gi = 0; gi < 4; gi++) begin : g_snap_byte
    assign snap_byte[gi] = snap_reg[8*gi +: 8];
  end

  // A read of byte 0 latches the whole counter so bytes 1-3 form a coherent value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt_reg <= '0;
      snap_reg      <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (rd_en && hit_ctrl_lo) snap_reg <= cycle_cnt_reg;
    end
  end
`endif

  logic [7:0] io_rdata;

  always_comb begin
    io_rdata = 8'h00;
    if (rd_en && hit_data && rx_nonempty) begin
      io_rdata = rx_mem[rx_rd_ptr_reg];
    end
`ifdef MEM_IO_CYCLE_COUNTER_EN
    else if (rd_en && hit_ctrl) begin
      io_rdata = hit_ctrl_lo ? cycle_cnt_reg[7:0] : snap_byte[addr[1:0]];
    end
`endif
  end

  // mem_din selects the RAM port only after a RAM read; everything else returns io_q_reg.
  logic       sel_ram_reg;
  logic [7:0] io_q_reg;
  logic       program_stop_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_ram_reg      <= 1'b0;
      io_q_reg         <= 8'h00;
      program_stop_reg <= 1'b0;
    end else begin
      sel_ram_reg <= is_ram & ~bus.mem_wr;
      io_q_reg    <= io_rdata;
      if (wr_en && hit_ctrl_lo) program_stop_reg <= 1'b1;
    end
  end

  assign bus.mem_din      = sel_ram_reg ? ram_q_reg : io_q_reg;
  assign bus.program_stop = program_stop_reg;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: vector table for RAM/decode reads plus
// hand-written sequences for the counter, RX/TX FIFOs, program stop and reset.
`timescale 1ns/1ps
module tb_mem_io_responder;
  logic clk_in = 1'b0;
  logic rst_in;

  mem_io_responder_if bus();

  mem_io_responder dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_din;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic access(input logic wr, input logic [31:0] a, input logic [7:0] d);
    bus.mem_wr   = wr;
    bus.mem_a    = a;
    bus.mem_dout = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) access(1'b0, 32'h0, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs [16];
    logic [7:0] tx_wr [10];
    logic       tx_full_exp [10];
    logic [7:0] exp_tx [9];

    vecs[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
    vecs[2]  = '{1'b1, 32'h0001_FFFF, 8'h3C, 8'h00};
    vecs[3]  = '{1'b0, 32'h0001_FFFF, 8'h00, 8'h3C};
    vecs[4]  = '{1'b1, 32'h0000_0020, 8'h77, 8'h00};
    vecs[5]  = '{1'b0, 32'h0000_0020, 8'h00, 8'h77};
    vecs[6]  = '{1'b1, 32'h0002_0010, 8'hEE, 8'h00};
    vecs[7]  = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
    vecs[8]  = '{1'b0, 32'h0002_0010, 8'h00, 8'h00};
    vecs[9]  = '{1'b0, 32'h0003_0008, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 32'h0003_0000, 8'h00, 8'h00};
    vecs[11] = '{1'b0, 32'h0003_FFFF, 8'h00, 8'h00};
    vecs[12] = '{1'b1, 32'h0001_0010, 8'h5A, 8'h00};
    vecs[13] = '{1'b0, 32'h0001_0010, 8'h00, 8'h5A};
    vecs[14] = '{1'b0, 32'h0000_0010, 8'h00, 8'hA5};
    vecs[15] = '{1'b0, 32'h1234_0010, 8'h00, 8'hA5};

    tx_wr       = '{8'h48, 8'h69, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    tx_full_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_tx      = '{8'h48, 8'h69, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h55};

    bus.mem_wr   = 1'b0;
    bus.mem_a    = 32'h0;
    bus.mem_dout = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    rst_in       = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset mem_din", {24'h0, bus.mem_din}, 32'h0);
    check("reset tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("reset rx_ready", {31'h0, bus.rx_ready}, 32'h1);
    check("reset io_buffer_full", {31'h0, bus.io_buffer_full}, 32'h0);
    check("reset program_stop", {31'h0, bus.program_stop}, 32'h0);
    rst_in = 1'b0;

    // 300 edges after reset release the counter holds 300 (0x12C).
    idle(300);
`ifdef MEM_IO_CYCLE_COUNTER_EN
    access(1'b0, 32'h0003_0004, 8'h00);
    check("counter byte0", {24'h0, bus.mem_din}, 32'h2C);
    access(1'b0, 32'h0003_0005, 8'h00);
    check("counter byte1", {24'h0, bus.mem_din}, 32'h01);
    access(1'b0, 32'h0003_0006, 8'h00);
    check("counter byte2", {24'h0, bus.mem_din}, 32'h00);
    access(1'b0, 32'h0003_0007, 8'h00);
    check("counter byte3", {24'h0, bus.mem_din}, 32'h00);
    idle(5);
    access(1'b0, 32'h0003_0005, 8'h00);
    check("snapshot held byte1", {24'h0, bus.mem_din}, 32'h01);
`else
    access(1'b0, 32'h0003_0004, 8'h00);
    check("no counter byte0", {24'h0, bus.mem_din}, 32'h00);
    access(1'b0, 32'h0003_0005, 8'h00);
    check("no counter byte1", {24'h0, bus.mem_din}, 32'h00);
`endif

    for (int i = 0; i < 16; i++) begin
      access(vecs[i].wr, vecs[i].a, vecs[i].d);
      check($sformatf("vec%0d %s 0x%0h", i, vecs[i].wr ? "wr" : "rd", vecs[i].a),
            {24'h0, bus.mem_din}, {24'h0, vecs[i].exp_din});
    end

    // RX: single byte, then fill to full and read back in order.
    bus.mem_wr   = 1'b0;
    bus.mem_a    = 32'h0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h41;
    check("rx_ready empty", {31'h0, bus.rx_ready}, 32'h1);
    @(posedge clk_in);
    #1;
    bus.rx_valid = 1'b0;
    access(1'b0, 32'h0003_0000, 8'h00);
    check("rx read 0x41", {24'h0, bus.mem_din}, 32'h41);
    access(1'b0, 32'h0003_0000, 8'h00);
    check("rx read empty", {24'h0, bus.mem_din}, 32'h00);
    bus.mem_a = 32'h0;
    for (int i = 0; i < 8; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'(8'h10 + i);
      @(posedge clk_in);
      #1;
    end
    check("rx_ready full", {31'h0, bus.rx_ready}, 32'h0);
    bus.rx_data = 8'hFF;
    @(posedge clk_in);
    #1;
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 32'h0003_0000, 8'h00);
      check($sformatf("rx drain %0d", i), {24'h0, bus.mem_din}, 32'(8'h10 + i));
    end
    access(1'b0, 32'h0003_0000, 8'h00);
    check("rx drained empty", {24'h0, bus.mem_din}, 32'h00);
    check("rx_ready after drain", {31'h0, bus.rx_ready}, 32'h1);

    // TX: fill with tx_ready low, overflow, then push+pop while full.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      access(1'b1, 32'h0003_0000, tx_wr[i]);
      check($sformatf("tx io_buffer_full after wr %0d", i),
            {31'h0, bus.io_buffer_full}, {31'h0, tx_full_exp[i]});
    end
    check("tx_valid filled", {31'h0, bus.tx_valid}, 32'h1);
    bus.tx_ready = 1'b1;
    check("tx head before pop", {24'h0, bus.tx_data}, {24'h0, exp_tx[0]});
    access(1'b1, 32'h0003_0000, 8'h55);
    check("tx full after push+pop", {31'h0, bus.io_buffer_full}, 32'h1);
    bus.mem_wr = 1'b0;
    bus.mem_a  = 32'h0;
    for (int k = 1; k < 9; k++) begin
      check($sformatf("tx drain %0d", k), {23'h0, bus.tx_valid, bus.tx_data},
            {23'h0, 1'b1, exp_tx[k]});
      idle(1);
    end
    check("tx_valid drained", {31'h0, bus.tx_valid}, 32'h0);
    check("io_buffer_full drained", {31'h0, bus.io_buffer_full}, 32'h0);

    // Program stop, then reset with 3 bytes queued.
    bus.tx_ready = 1'b0;
    access(1'b1, 32'h0000_0100, 8'hC3);
    check("program_stop before", {31'h0, bus.program_stop}, 32'h0);
    access(1'b1, 32'h0003_0004, 8'hFF);
    check("program_stop set", {31'h0, bus.program_stop}, 32'h1);
    check("stop tx byte", {23'h0, bus.tx_valid, bus.tx_data}, {23'h0, 1'b1, 8'h00});
    access(1'b1, 32'h0003_0000, 8'h61);
    access(1'b1, 32'h0003_0000, 8'h62);
    idle(3);
    check("program_stop sticky", {31'h0, bus.program_stop}, 32'h1);
    check("io_buffer_full at 3", {31'h0, bus.io_buffer_full}, 32'h0);
    rst_in       = 1'b1;
    bus.mem_wr   = 1'b1;
    bus.mem_a    = 32'h0000_0100;
    bus.mem_dout = 8'h11;
    @(posedge clk_in);
    #1;
    check("rst tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("rst io_buffer_full", {31'h0, bus.io_buffer_full}, 32'h0);
    check("rst program_stop", {31'h0, bus.program_stop}, 32'h0);
    check("rst mem_din", {24'h0, bus.mem_din}, 32'h0);
    rst_in       = 1'b0;
    bus.tx_ready = 1'b1;
    access(1'b0, 32'h0000_0100, 8'h00);
    check("ram kept through reset", {24'h0, bus.mem_din}, 32'hC3);
    access(1'b0, 32'h0003_0005, 8'h00);
    check("snapshot cleared", {24'h0, bus.mem_din}, 32'h00);
    check("tx empty after reset", {31'h0, bus.tx_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
